// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and March C- element constants for the SRAM BIST
package sram_bist_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } bist_state_t;

  // Bit n of each mask describes element Mn.
  localparam logic [5:0] ELEM_DOWN   = 6'b011000;  // M3, M4 walk downwards
  localparam logic [5:0] ELEM_HAS_RD = 6'b111110;  // every element except M0 reads
  localparam logic [5:0] ELEM_RD_B1  = 6'b010100;  // M2, M4 expect all ones
  localparam logic [5:0] ELEM_WR_B1  = 6'b001010;  // M1, M3 write all ones

endpackage

// File: rtl/sram_march_addr_gen.sv
// rtl/sram_march_addr_gen.sv - up/down word-address counter with load, step and terminal count
module sram_march_addr_gen #(
  parameter int WORD_AW = 30,
  parameter int WORDS   = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_load_down,
  input  logic               i_step,
  output logic [WORD_AW-1:0] o_addr,
  output logic               o_tc
);

  localparam logic [WORD_AW-1:0] LAST = WORD_AW'(WORDS - 1);
  localparam logic [WORD_AW-1:0] ONE  = WORD_AW'(1);

  logic               r_down;
  logic [WORD_AW-1:0] r_addr;

  // Load picks the element's first address and latches its direction; step walks it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_load_down ? LAST : '0;
      r_down <= i_load_down;
    end else if (i_step) begin
      r_addr <= r_down ? (r_addr - ONE) : (r_addr + ONE);
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = r_down ? (r_addr == '0) : (r_addr == LAST);

endmodule

// File: rtl/sram_sp_march_bist.sv
// rtl/sram_sp_march_bist.sv - March C- BIST initiator for a single-port SRAM with first-fail capture
module sram_sp_march_bist
  import sram_bist_pkg::*;
#(
  parameter  int DW      = 32,
  parameter  int AW      = 32,
  parameter  int WORDS   = 1024,
  localparam int SW      = DW / 8,
  localparam int WORD_AW = AW - $clog2(SW)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fail,
  output logic [WORD_AW-1:0] o_fail_addr,
  output logic [2:0]         o_fail_elem,
  output logic               o_sram_ce,
  output logic               o_sram_we,
  output logic               o_sram_oe,
  output logic [WORD_AW-1:0] o_sram_waddr,
  output logic [DW-1:0]      o_sram_din,
  output logic [SW-1:0]      o_sram_sel,
  input  logic [DW-1:0]      i_sram_dout
);

  bist_state_t        r_state;
  march_elem_t        r_elem;        // element of the access currently on the bus
  logic               r_cmp_valid;
  logic               r_cmp_exp_b1;
  logic               r_cmp_last;
  logic [WORD_AW-1:0] r_cmp_addr;
  logic [2:0]         r_cmp_elem;

  logic [WORD_AW-1:0] w_addr;
  logic               w_tc;
  logic               w_mismatch;
  logic               w_final;
  logic               w_addr_done;
  logic               w_issue;
  logic               w_start_ok;
  logic               w_load;
  logic               w_load_down;
  logic               w_step;
  logic               w_next_we;
  march_elem_t        w_next_elem;

  // The bus access in flight: a write ends its address, as does M5's lone read.
  assign w_addr_done = o_sram_we || (r_elem == M5);
  assign w_final     = (r_elem == M5) && w_tc;
  assign w_mismatch  = (r_state == S_RUN) && r_cmp_valid && (i_sram_dout != {DW{r_cmp_exp_b1}});
  assign w_issue     = (r_state == S_RUN) && o_sram_ce && !w_final && !w_mismatch;
  assign w_start_ok  = (r_state != S_RUN) && i_start;
  assign w_next_elem = march_elem_t'(r_elem + 3'd1);
  assign w_load      = w_start_ok || (w_issue && w_addr_done && w_tc);
  assign w_load_down = w_start_ok ? 1'b0 : ELEM_DOWN[w_next_elem];
  assign w_step      = w_issue && w_addr_done && !w_tc;
  // A new address or element always opens with its read, except in write-only M0.
  assign w_next_we   = !w_addr_done ? 1'b1 : (w_tc ? 1'b0 : !ELEM_HAS_RD[r_elem]);

  sram_march_addr_gen #(
    .WORD_AW (WORD_AW),
    .WORDS   (WORDS)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .o_addr      (w_addr),
    .o_tc        (w_tc)
  );

  assign o_sram_waddr = w_addr;

  // Control FSM: issues one access per cycle and compares each read one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_elem       <= M0;
      r_cmp_valid  <= 1'b0;
      r_cmp_exp_b1 <= 1'b0;
      r_cmp_last   <= 1'b0;
      r_cmp_addr   <= '0;
      r_cmp_elem   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_fail       <= 1'b0;
      o_fail_addr  <= '0;
      o_fail_elem  <= '0;
      o_sram_ce    <= 1'b0;
      o_sram_we    <= 1'b0;
      o_sram_oe    <= 1'b0;
      o_sram_din   <= '0;
      o_sram_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_elem      <= M0;
            r_cmp_valid <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_fail_addr <= '0;
            o_fail_elem <= '0;
            o_sram_ce   <= 1'b1;
            o_sram_we   <= 1'b1;
            o_sram_oe   <= 1'b0;
            o_sram_din  <= '0;
            o_sram_sel  <= '1;
          end
        end
        S_RUN: begin
          if (w_mismatch || (r_cmp_valid && r_cmp_last)) begin
            r_state     <= S_DONE;
            r_cmp_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            o_sram_ce   <= 1'b0;
            o_sram_we   <= 1'b0;
            o_sram_oe   <= 1'b0;
            o_sram_din  <= '0;
            o_sram_sel  <= '0;
            if (w_mismatch) begin
              o_fail      <= 1'b1;
              o_fail_addr <= r_cmp_addr;
              o_fail_elem <= r_cmp_elem;
            end
          end else begin
            r_cmp_valid  <= o_sram_ce && !o_sram_we;
            r_cmp_addr   <= w_addr;
            r_cmp_elem   <= r_elem;
            r_cmp_exp_b1 <= ELEM_RD_B1[r_elem];
            r_cmp_last   <= w_final;
            if (w_issue) begin
              o_sram_ce  <= 1'b1;
              o_sram_we  <= w_next_we;
              o_sram_oe  <= !w_next_we;
              o_sram_din <= {DW{w_next_we && ELEM_WR_B1[r_elem]}};
              o_sram_sel <= '1;
              if (w_addr_done && w_tc) r_elem <= w_next_elem;
            end else begin
              o_sram_ce  <= 1'b0;
              o_sram_we  <= 1'b0;
              o_sram_oe  <= 1'b0;
              o_sram_din <= '0;
              o_sram_sel <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_sp_march_bist.md
# sram_sp_march_bist

Built-in self-test controller that acts as the initiator on the single-port SRAM port (`ce`/`we`/`oe`/`waddr`/`din`/`sel` → `dout`). On `start` it runs a March C- sequence over the lowest `WORDS` word addresses, compares every read against the expected background, and reports pass/fail with the first failing address and march element. It sits in front of each tile's `sram_sp`, muxed in by the memory subsystem while the tile is held out of service.

## Interface
Parameters:
- `DW`, 32: data width; 32, 16 or 8.
- `AW`, 32: byte address width.
- `SW`, derived: byte-select width, DW/8.
- `WORD_AW`, derived: AW − log2(SW).
- `WORDS`, 1024: number of words tested from word address 0; 1 ≤ WORDS ≤ 2^WORD_AW.

Ports (clock and reset first):
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a test.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until next accepted `start`.
- `fail`  out  1  mismatch detected; valid while `done`.
- `fail_addr`  out  WORD_AW  word address of first mismatch.
- `fail_elem`  out  3  march element (0..5) of first mismatch.
- `sram_ce`  out  1  chip enable.
- `sram_we`  out  1  write enable.
- `sram_oe`  out  1  output enable; equals ce & ~we.
- `sram_waddr`  out  WORD_AW  word address.
- `sram_din`  out  DW  write data.
- `sram_sel`  out  SW  byte select; always all ones when ce.
- `sram_dout`  in  DW  read data, valid the cycle after a read.

## Operation
- All outputs are registered; every output resets to 0.
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after the final compare, or immediately after the first mismatch compare.
  - DONE→RUN on `start`; entering RUN clears `done`, `fail`, `fail_addr` and `fail_elem`.
- `start` is ignored while in RUN.
- Elements, with B0 = all zeros and B1 = all ones:
  - M0 ⇑ w B0
  - M1 ⇑ (r B0, w B1)
  - M2 ⇑ (r B1, w B0)
  - M3 ⇓ (r B0, w B1)
  - M4 ⇓ (r B1, w B0)
  - M5 ⇑ r B0
- ⇑ runs address 0..WORDS−1; ⇓ runs WORDS−1..0.
- Read/write elements take 2 cycles per address, read first. M0 and M5 take 1 cycle per address. Total is 10·WORDS access cycles with no idle cycles between elements.
- Compare pipeline: the read address, expected value and element are registered with the read. `sram_dout` is compared the next cycle, in parallel with the following access.
- On mismatch:
  - `fail`, `fail_addr` and `fail_elem` are latched.
  - The access issued in the compare cycle completes.
  - No further access is issued and the FSM goes to DONE.
- Address counter width is WORD_AW. Terminal detect is at WORDS−1 (⇑) or 0 (⇓), so there is no wrap past the test range.

## Timing
- `start` is sampled in cycle 0. The first access (`sram_ce`=1) is in cycle 1.
- Passing run:
  - Last access in cycle 10·WORDS.
  - Last compare in cycle 10·WORDS+1.
  - `busy`=1 for cycles 1..10·WORDS+1.
  - `done`=1 from cycle 10·WORDS+2.
- Failing run: `done`=1 two cycles after the failing read was issued. `busy` drops in the same cycle `done` rises.
- Asynchronous `rst` mid-run immediately forces `sram_ce`/`sram_we`/`sram_oe`=0 and state IDLE. Memory contents are then undefined.
- WORDS=1: the ⇓ elements degenerate to the single address 0, giving 10 access cycles.

## Structure
- Package `sram_bist_pkg` holds:
  - `march_elem_t` enum M0..M5;
  - per-element constants: direction, read background, write background;
  - `bist_state_t` enum.
- One sub-module `sram_march_addr_gen`: up/down word-address counter with load-start, step and terminal-count output.
- The FSM, access issue and compare pipeline live in the top module.

## Test plan
- Good memory (`sram_sp`, DW=32, WORDS=16): start → 160 accesses; `done`=1 at cycle 162; `fail`=0.
- Stuck-at-1 on bit 3 of word 5 (fault model): → `fail`=1, `fail_addr`=5, `fail_elem`=1, no access after the compare cycle.
- Coupling fault, writing B1 to word 9 sets word 10 to B1: → `fail`=1, `fail_addr`=10, `fail_elem`=1.
- `start` pulsed at cycle 40 of a run: ignored, completion still at cycle 162. A second `start` after `done` clears `done`/`fail` in the next cycle and reruns.
- `rst` at cycle 50: all outputs 0 at once, `sram_ce`=0. A later `start` completes a full 162-cycle pass.
- WORDS=1, good memory: 10 accesses to address 0 in the order w, r, w, r, w, r, w, r, w, r; `done` at cycle 12, `fail`=0.
